// File: rtl/pipe_egress_pkg.sv
// Shared definitions for the pipeline egress credit buffer: default sizing,
// FIFO operation encoding and the non-power-of-2 pointer wrap helper.
package pipe_egress_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 5;

  // FIFO operation for one cycle, encoded as {write_accepted, read_accepted}
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_RD   = 2'b01,
    FIFO_WR   = 2'b10,
    FIFO_RW   = 2'b11
  } fifo_op_e;

  // Advance a circular pointer, wrapping from depth-1 back to 0 by compare
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pipe_egress_fifo.sv
// Circular FIFO holding pipeline results until the consumer accepts them.
// Any DEPTH >= 2 is supported; pointers wrap by explicit compare.
module pipe_egress_fifo
  import pipe_egress_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  full;
  logic                  empty;
  logic                  rd_acc;
  logic                  wr_acc;
  fifo_op_e              op;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_acc  = rd_en && !empty;
  // A full buffer still accepts a write when the head leaves in the same cycle
  assign wr_acc  = wr_en && (!full || rd_acc);
  assign op      = fifo_op_e'({wr_acc, rd_acc});
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= PTR_W'(ptr_next(32'(wr_ptr), DEPTH));
      if (rd_acc) rd_ptr <= PTR_W'(ptr_next(32'(rd_ptr), DEPTH));
      case (op)
        FIFO_WR: count_q <= count_q + CNT_W'(1);
        FIFO_RD: count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pipe_egress_credit_buffer.sv
// Egress buffer behind a fixed-latency valid-only pipeline. Credits gate the
// pipeline input so every issued item owns a buffer slot when it exits, and
// the buffered words are offered to a ready/valid consumer.
// Optional feature: define PIPE_EGRESS_OVF_CHECK_EN to build the sticky
// overflow detector; otherwise overflow is tied low.
module pipe_egress_credit_buffer
  import pipe_egress_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up_valid,
  output logic                       up_ready,
  output logic                       issue_valid,
  input  logic                       pipe_valid,
  input  logic [DATA_WIDTH-1:0]      pipe_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic                       overflow
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0] credits_q;
  logic [CNT_W-1:0] fifo_count;
  logic             issue;
  logic             pop;

  assign up_ready    = (credits_q != '0);
  assign issue       = up_valid && up_ready;
  assign issue_valid = issue;
  assign out_valid   = (fifo_count != '0);
  assign pop         = out_valid && out_ready;
  assign credits     = credits_q;

  pipe_egress_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pipe_valid),
    .wr_data (pipe_data),
    .rd_en   (pop),
    .rd_data (out_data),
    .count   (fifo_count)
  );

  // Credit counter: issue consumes a credit, pop returns one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CNT_W'(DEPTH);
    end else begin
      case ({issue, pop})
        2'b10:   credits_q <= credits_q - CNT_W'(1);
        2'b01:   credits_q <= credits_q + CNT_W'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

`ifdef PIPE_EGRESS_OVF_CHECK_EN
  logic [CNT_W:0] committed;
  logic           fifo_full;
  logic           ovf_event;
  logic           overflow_q;

  assign committed = {1'b0, credits_q} + {1'b0, fifo_count};
  assign fifo_full = (fifo_count == CNT_W'(DEPTH));
  // A result with no outstanding issue, or one landing on a full buffer, is a protocol error
  assign ovf_event = pipe_valid &&
                     ((fifo_full && !pop) || (committed == (CNT_W+1)'(DEPTH)));
  assign overflow  = overflow_q;

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else if (ovf_event) overflow_q <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_egress_credit_buffer.sv
// Self-checking bench for pipe_egress_credit_buffer with DEPTH=5 and a
// 3-stage pipeline model (output = issued word + 1). Expected values come
// from a queue-based reference of the buffer plus a credit tally.
module tb_pipe_egress_credit_buffer;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 5;
  localparam int LAT        = 3;
  localparam int CNT_W      = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  up_valid;
  logic                  up_ready;
  logic                  issue_valid;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]      credits;
  logic                  overflow;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  int          m_credits;
  bit          m_ovf;
  bit          st_v[LAT];
  logic [31:0] st_d[LAT];
  logic [31:0] next_word;
  int          dut_issues;

  always #5 clk = ~clk;

  pipe_egress_credit_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .issue_valid (issue_valid),
    .pipe_valid  (pipe_valid),
    .pipe_data   (pipe_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .credits     (credits),
    .overflow    (overflow)
  );

  // Safety net so the run always terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState();
    checkOutput("credits",   32'(credits),             32'(m_credits));
    checkOutput("up_ready",  32'(up_ready),            32'(m_credits != 0));
    checkOutput("out_valid", 32'(out_valid),           32'(exp_q.size() != 0));
    checkOutput("overflow",  32'(overflow),            32'(m_ovf));
    checkOutput("count",     32'(dut.u_fifo.count_q),  32'(exp_q.size()));
    if (exp_q.size() != 0) checkOutput("out_data", out_data, exp_q[0]);
  endtask

  task automatic clearModel();
    exp_q.delete();
    m_credits = DEPTH;
    m_ovf     = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      st_v[i] = 1'b0;
      st_d[i] = '0;
    end
  endtask

  // One clock cycle: drive at negedge, update model at posedge, check at next negedge
  task automatic applyStimulus(input logic uv, input logic ordy, input logic inj);
    bit exp_iss;
    bit pop;
    bit was_full;
    up_valid   = uv;
    out_ready  = ordy;
    pipe_valid = st_v[LAT-1] | inj;
    pipe_data  = inj ? (32'hA500_0000 | next_word) : st_d[LAT-1];
    #1;
    exp_iss = uv && (m_credits != 0);
    checkOutput("issue_valid", 32'(issue_valid), 32'(exp_iss));
    if (issue_valid) dut_issues++;
    @(posedge clk);
    pop      = (exp_q.size() != 0) && ordy;
    was_full = (exp_q.size() == DEPTH);
`ifdef PIPE_EGRESS_OVF_CHECK_EN
    if (pipe_valid && ((was_full && !pop) || (m_credits + exp_q.size() == DEPTH))) m_ovf = 1'b1;
`endif
    if (pop) void'(exp_q.pop_front());
    if (pipe_valid && (!was_full || pop)) exp_q.push_back(pipe_data);
    m_credits = m_credits + (pop ? 1 : 0) - (exp_iss ? 1 : 0);
    for (int i = LAT-1; i > 0; i--) begin
      st_v[i] = st_v[i-1];
      st_d[i] = st_d[i-1];
    end
    st_v[0] = exp_iss;
    st_d[0] = next_word + 32'd1;
    if (exp_iss) next_word = next_word + 32'd1;
    @(negedge clk);
    checkState();
  endtask

  // Asynchronous reset mid-cycle with a spurious pipe_valid pulse held during it
  task automatic doReset();
    #2;
    up_valid   = 1'b0;
    out_ready  = 1'b0;
    pipe_valid = 1'b1;
    pipe_data  = 32'h0000_0BAD;
    rst        = 1'b1;
    #1;
    checkOutput("rst_credits",   32'(credits),   DEPTH);
    checkOutput("rst_up_ready",  32'(up_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_overflow",  32'(overflow),  32'd0);
    clearModel();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    pipe_valid = 1'b0;
    #1;
    checkState();
  endtask

  initial begin
    up_valid   = 1'b0;
    out_ready  = 1'b0;
    pipe_valid = 1'b0;
    pipe_data  = '0;
    next_word  = 32'd100;
    dut_issues = 0;
    clearModel();

    $display("[TB] reset and idle");
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkState();
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] back-to-back issue with consumer always ready");
    dut_issues = 0;
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("burst_issues", 32'(dut_issues), 32'd20);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("burst_credits", 32'(credits), DEPTH);

    $display("[TB] backpressure: credits run out");
    dut_issues = 0;
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stall_issues", 32'(dut_issues), 32'd5);
    checkOutput("stall_count", 32'(dut.u_fifo.count_q), 32'd5);
    checkOutput("stall_up_ready", 32'(up_ready), 32'd0);
    repeat (7) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("drain_credits", 32'(credits), DEPTH);

    $display("[TB] full buffer with write and pop together across wrap");
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("full_rw_count", 32'(dut.u_fifo.count_q), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("full_rw_count2", 32'(dut.u_fifo.count_q), 32'd5);
    repeat (7) applyStimulus(1'b0, 1'b1, 1'b0);
    doReset();

    $display("[TB] result with no outstanding issue");
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef PIPE_EGRESS_OVF_CHECK_EN
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
`else
    checkOutput("ovf_tied", 32'(overflow), 32'd0);
`endif
    doReset();

    $display("[TB] reset with items buffered and in flight");
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(dut.u_fifo.count_q), 32'd3);
    checkOutput("pre_rst_credits", 32'(credits), 32'd0);
    doReset();
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_credits", 32'(credits), DEPTH);

    $display("[TB] random traffic");
    repeat (80) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("final_credits", 32'(credits), DEPTH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
